// File: rtl/histogram_eq_master_fsm_if.sv
// Request/core signal bundle for the histogram equalizer master sequencer.
// Signalling: there is no valid/ready pair here. start_in and abort_in are levels that are
// sampled on every rising clock edge. The core's *_done inputs are honoured only in the phase
// they belong to. start_* and done are single-cycle pulses. busy, error and
// input_mem_read_finished are levels.
interface histogram_eq_master_fsm_if;
   logic        start_in;
   logic        abort_in;
   logic [1:0]  input_rd_words;
   logic        histogram_computation_done;
   logic        cdf_done;
   logic        divider_done;
   logic        start_histogram;
   logic        start_cdf;
   logic        start_divider;
   logic        input_mem_read_finished;
   logic        busy;
   logic        done;
   logic        error;
   logic [2:0]  phase;
   logic [31:0] run_cycles;

   modport master (
      input  start_in, abort_in, input_rd_words,
             histogram_computation_done, cdf_done, divider_done,
      output start_histogram, start_cdf, start_divider, input_mem_read_finished,
             busy, done, error, phase, run_cycles
   );

   modport slave (
      output start_in, abort_in, input_rd_words,
             histogram_computation_done, cdf_done, divider_done,
      input  start_histogram, start_cdf, start_divider, input_mem_read_finished,
             busy, done, error, phase, run_cycles
   );
endinterface

// File: rtl/histogram_eq_master_fsm.sv
// Master sequencer for the histogram equalizer: histogram -> CDF -> divider, with an
// input-word counter, a per-phase watchdog and a run-length counter. Every output is a flop.
// The phase output is the state register itself, so it also serves as the FSM debug view.
module histogram_eq_master_fsm #(
   parameter int NUM_INPUT_WORDS = 4096,
   parameter int CNT_W           = 17,
   parameter int TIMEOUT_CYCLES  = 65535,
   parameter int TO_W            = 16
) (
   input logic                        clock,
   input logic                        reset,
   histogram_eq_master_fsm_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HIST = 3'd1,
      S_CDF  = 3'd2,
      S_DIV  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_e;

   localparam logic [CNT_W:0]   NUM_WIDE = (CNT_W+1)'(NUM_INPUT_WORDS);
   localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_INPUT_WORDS);
   localparam logic [TO_W-1:0]  WD_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic [31:0]       run_q, run_d;
   logic              start_hist_q, start_hist_d;
   logic              start_cdf_q, start_cdf_d;
   logic              start_div_q, start_div_d;
   logic              finished_q, finished_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              accept;
   logic              in_run;
   logic              wd_expired;
   logic [1:0]        rd_words;
   logic [CNT_W:0]    word_sum;

   // Next-state: abort beats the phase's own done input, which beats watchdog expiry.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      in_run     = (state_q == S_HIST) || (state_q == S_CDF) || (state_q == S_DIV);
      // The watchdog has counted TIMEOUT_CYCLES-1 earlier cycles, so this is the last allowed one.
      wd_expired = in_run && (wd_q == WD_LAST);
      case (state_q)
         S_IDLE, S_ERR: begin
            if (bus.start_in) begin
               state_d = S_HIST;
               accept  = 1'b1;
            end
         end
         S_HIST: begin
            if (bus.abort_in)                        state_d = S_IDLE;
            else if (bus.histogram_computation_done) state_d = S_CDF;
            else if (wd_expired)                     state_d = S_ERR;
         end
         S_CDF: begin
            if (bus.abort_in)      state_d = S_IDLE;
            else if (bus.cdf_done) state_d = S_DIV;
            else if (wd_expired)   state_d = S_ERR;
         end
         S_DIV: begin
            if (bus.abort_in)          state_d = S_IDLE;
            else if (bus.divider_done) state_d = S_DONE;
            else if (wd_expired)       state_d = S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Counters and registered outputs, all derived from the current/next state pair.
   always_comb begin
      rd_words = (bus.input_rd_words == 2'd3) ? 2'd2 : bus.input_rd_words;
      word_sum = {1'b0, word_cnt_q} + {{(CNT_W-1){1'b0}}, rd_words};

      word_cnt_d = word_cnt_q;
      if (accept) begin
         word_cnt_d = '0;
      end else if (state_q == S_HIST) begin
         word_cnt_d = (word_sum >= NUM_WIDE) ? NUM_CNT : word_sum[CNT_W-1:0];
      end

      // Finished rises on the cycle after the read that completes the image.
      finished_d = finished_q;
      if (accept || (state_d == S_IDLE)) begin
         finished_d = 1'b0;
      end else if ((state_q == S_HIST) && (word_sum >= NUM_WIDE)) begin
         finished_d = 1'b1;
      end

      wd_d = '0;
      if ((state_d == state_q) && in_run) begin
         wd_d = wd_q + 1'b1;
      end

      run_d = run_q;
      if (accept) begin
         run_d = '0;
      end else if (in_run) begin
         run_d = run_q + 32'd1;
      end

      error_d = error_q;
      if (accept) begin
         error_d = 1'b0;
      end else if ((state_d == S_ERR) && (state_q != S_ERR)) begin
         error_d = 1'b1;
      end

      start_hist_d = accept;
      start_cdf_d  = (state_q == S_HIST) && (state_d == S_CDF);
      start_div_d  = (state_q == S_CDF) && (state_d == S_DIV);
      done_d       = (state_d == S_DONE);
      busy_d       = (state_d == S_HIST) || (state_d == S_CDF) || (state_d == S_DIV);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         word_cnt_q   <= '0;
         wd_q         <= '0;
         run_q        <= '0;
         start_hist_q <= 1'b0;
         start_cdf_q  <= 1'b0;
         start_div_q  <= 1'b0;
         finished_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         wd_q         <= wd_d;
         run_q        <= run_d;
         start_hist_q <= start_hist_d;
         start_cdf_q  <= start_cdf_d;
         start_div_q  <= start_div_d;
         finished_q   <= finished_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign bus.start_histogram         = start_hist_q;
   assign bus.start_cdf               = start_cdf_q;
   assign bus.start_divider           = start_div_q;
   assign bus.input_mem_read_finished = finished_q;
   assign bus.busy                    = busy_q;
   assign bus.done                    = done_q;
   assign bus.error                   = error_q;
   assign bus.phase                   = state_q;
   assign bus.run_cycles              = run_q;

endmodule

// File: tb/tb_histogram_eq_master_fsm.sv
// Bench for histogram_eq_master_fsm: directed scenarios with literal expectations, then
// random traffic, with a behavioural model compared against the DUT on every cycle.
module tb_histogram_eq_master_fsm;
   localparam int NUM_WORDS = 64;
   localparam int TIMEOUT   = 100;
   localparam int P_IDLE = 0, P_HIST = 1, P_CDF = 2, P_DIV = 3, P_DONE = 4, P_ERR = 5;

   logic clock = 1'b0;
   logic reset;
   bit   cmp_en = 1'b0;
   int   errors = 0;
   int   checks = 0;

   histogram_eq_master_fsm_if bus();

   histogram_eq_master_fsm #(
      .NUM_INPUT_WORDS(NUM_WORDS), .CNT_W(8), .TIMEOUT_CYCLES(TIMEOUT), .TO_W(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Clock and reset
   always #5 clock = ~clock;

   // Model state: phase, words read this run, cycles spent in the current phase
   int          m_phase = 0;
   int          m_words = 0;
   int          m_in_phase = 0;
   logic [31:0] e_run = '0;
   bit          e_start_hist = 0, e_start_cdf = 0, e_start_div = 0;
   bit          e_finished = 0, e_busy = 0, e_done = 0, e_error = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model, advanced on each rising edge from the sampled inputs
   always @(posedge clock) begin : model
      int nxt;
      int rd;
      bit busy_now;
      bit accept;
      bit own_done;
      if (reset) begin
         m_phase = P_IDLE; m_words = 0; m_in_phase = 0; e_run = '0;
         e_start_hist = 0; e_start_cdf = 0; e_start_div = 0;
         e_finished = 0; e_busy = 0; e_done = 0; e_error = 0;
      end else begin
         busy_now = (m_phase >= P_HIST) && (m_phase <= P_DIV);
         rd = (int'(bus.input_rd_words) > 2) ? 2 : int'(bus.input_rd_words);
         case (m_phase)
            P_HIST:  own_done = bus.histogram_computation_done;
            P_CDF:   own_done = bus.cdf_done;
            P_DIV:   own_done = bus.divider_done;
            default: own_done = 1'b0;
         endcase
         nxt = m_phase;
         accept = 0;
         if ((m_phase == P_IDLE || m_phase == P_ERR) && bus.start_in) begin
            nxt = P_HIST;
            accept = 1;
         end else if (m_phase == P_DONE) begin
            nxt = P_IDLE;
         end else if (busy_now) begin
            if (bus.abort_in)                    nxt = P_IDLE;
            else if (own_done)                   nxt = m_phase + 1;
            else if (m_in_phase + 1 >= TIMEOUT)  nxt = P_ERR;
         end

         e_start_hist = accept;
         e_start_cdf  = (m_phase == P_HIST) && (nxt == P_CDF);
         e_start_div  = (m_phase == P_CDF) && (nxt == P_DIV);
         e_done       = (nxt == P_DONE);
         e_busy       = (nxt >= P_HIST) && (nxt <= P_DIV);

         if (accept) begin
            m_words = 0; e_run = '0; e_error = 0; e_finished = 0;
         end else begin
            if (busy_now) e_run = e_run + 32'd1;
            if (m_phase == P_HIST) m_words = (m_words + rd > NUM_WORDS) ? NUM_WORDS : m_words + rd;
            if (nxt == P_IDLE) e_finished = 0;
            else if (m_phase == P_HIST && m_words == NUM_WORDS) e_finished = 1;
            if (nxt == P_ERR && m_phase != P_ERR) e_error = 1;
         end
         m_in_phase = (nxt == m_phase) ? m_in_phase + 1 : 0;
         m_phase = nxt;
      end
   end

   // Scoreboard compare, away from the active edge
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("phase",           32'(bus.phase),         32'(m_phase));
         chk("start_histogram", 32'(bus.start_histogram), 32'(e_start_hist));
         chk("start_cdf",       32'(bus.start_cdf),     32'(e_start_cdf));
         chk("start_divider",   32'(bus.start_divider), 32'(e_start_div));
         chk("rd_finished",     32'(bus.input_mem_read_finished), 32'(e_finished));
         chk("busy",            32'(bus.busy),          32'(e_busy));
         chk("done",            32'(bus.done),          32'(e_done));
         chk("error",           32'(bus.error),         32'(e_error));
         chk("run_cycles",      bus.run_cycles,         e_run);
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      bus.start_in = 1'b0;
      bus.abort_in = 1'b0;
      bus.input_rd_words = 2'd0;
      bus.histogram_computation_done = 1'b0;
      bus.cdf_done = 1'b0;
      bus.divider_done = 1'b0;
   endtask

   task automatic drive_random();
      reset = ($urandom_range(0, 499) == 0);
      bus.start_in = ($urandom_range(0, 3) == 0);
      bus.abort_in = ($urandom_range(0, 79) == 0);
      bus.input_rd_words = 2'($urandom_range(0, 3));
      bus.histogram_computation_done = ($urandom_range(0, 39) == 0);
      bus.cdf_done = ($urandom_range(0, 39) == 0);
      bus.divider_done = ($urandom_range(0, 39) == 0);
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      cmp_en = 1'b1;
      chk("rst_phase", 32'(bus.phase), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_run", bus.run_cycles, 32'd0);
      chk("rst_finished", 32'(bus.input_mem_read_finished), 32'd0);
      reset = 1'b0;

      // Nominal run: dones at t20/t40/t60
      bus.start_in = 1'b1; tick();
      chk("t1_start_hist", 32'(bus.start_histogram), 32'd1);
      chk("t1_phase", 32'(bus.phase), 32'd1);
      bus.start_in = 1'b0;
      repeat (19) tick();
      bus.histogram_computation_done = 1'b1; tick();
      chk("t21_start_cdf", 32'(bus.start_cdf), 32'd1);
      chk("t21_phase", 32'(bus.phase), 32'd2);
      bus.histogram_computation_done = 1'b0;
      repeat (19) tick();
      bus.cdf_done = 1'b1; tick();
      chk("t41_start_div", 32'(bus.start_divider), 32'd1);
      chk("t41_phase", 32'(bus.phase), 32'd3);
      bus.cdf_done = 1'b0;
      repeat (19) tick();
      bus.divider_done = 1'b1; tick();
      chk("t61_done", 32'(bus.done), 32'd1);
      chk("t61_phase", 32'(bus.phase), 32'd4);
      chk("t61_run", bus.run_cycles, 32'd60);
      bus.divider_done = 1'b0; tick();
      chk("t62_phase", 32'(bus.phase), 32'd0);
      chk("t62_done", 32'(bus.done), 32'd0);
      chk("t62_run", bus.run_cycles, 32'd60);

      // Word count: 2 words/cycle, image is NUM_WORDS words
      bus.start_in = 1'b1; tick();
      bus.start_in = 1'b0; bus.input_rd_words = 2'd2;
      repeat (NUM_WORDS / 2 - 1) tick();
      chk("wc_not_yet", 32'(bus.input_mem_read_finished), 32'd0);
      tick();
      chk("wc_finished", 32'(bus.input_mem_read_finished), 32'd1);
      bus.input_rd_words = 2'd3;
      repeat (5) tick();
      chk("wc_held", 32'(bus.input_mem_read_finished), 32'd1);
      bus.input_rd_words = 2'd0; bus.abort_in = 1'b1; tick();
      chk("wc_abort_phase", 32'(bus.phase), 32'd0);
      chk("wc_abort_drop", 32'(bus.input_mem_read_finished), 32'd0);
      bus.abort_in = 1'b0;

      // Watchdog in CDF
      bus.start_in = 1'b1; tick();
      bus.start_in = 1'b0; bus.histogram_computation_done = 1'b1; tick();
      bus.histogram_computation_done = 1'b0;
      repeat (TIMEOUT - 1) tick();
      chk("wd_still_cdf", 32'(bus.phase), 32'd2);
      tick();
      chk("wd_err_phase", 32'(bus.phase), 32'd5);
      chk("wd_error", 32'(bus.error), 32'd1);
      chk("wd_busy", 32'(bus.busy), 32'd0);
      bus.start_in = 1'b1; tick();
      chk("wd_restart_phase", 32'(bus.phase), 32'd1);
      chk("wd_restart_error", 32'(bus.error), 32'd0);
      bus.start_in = 1'b0;

      // Abort together with cdf_done
      bus.histogram_computation_done = 1'b1; tick();
      bus.histogram_computation_done = 1'b0;
      bus.abort_in = 1'b1; bus.cdf_done = 1'b1; tick();
      chk("ab_phase", 32'(bus.phase), 32'd0);
      chk("ab_no_start_div", 32'(bus.start_divider), 32'd0);
      bus.abort_in = 1'b0; bus.cdf_done = 1'b0;

      // Histogram done on the expiry cycle
      bus.start_in = 1'b1; tick();
      bus.start_in = 1'b0;
      repeat (TIMEOUT - 1) tick();
      chk("exp_still_hist", 32'(bus.phase), 32'd1);
      bus.histogram_computation_done = 1'b1; tick();
      chk("exp_phase", 32'(bus.phase), 32'd2);
      chk("exp_no_error", 32'(bus.error), 32'd0);
      bus.histogram_computation_done = 1'b0;

      // Spurious inputs
      bus.abort_in = 1'b1; tick();
      bus.abort_in = 1'b0; bus.start_in = 1'b1; tick();
      bus.start_in = 1'b0; bus.cdf_done = 1'b1; bus.divider_done = 1'b1; tick();
      chk("sp_hist_stay", 32'(bus.phase), 32'd1);
      bus.cdf_done = 1'b0; bus.divider_done = 1'b0;
      bus.histogram_computation_done = 1'b1; tick();
      bus.histogram_computation_done = 1'b0; bus.cdf_done = 1'b1; tick();
      bus.cdf_done = 1'b0; bus.start_in = 1'b1; tick();
      chk("sp_div_stay", 32'(bus.phase), 32'd3);
      chk("sp_no_start_hist", 32'(bus.start_histogram), 32'd0);
      bus.start_in = 1'b0;

      // Reset mid-DIV, then a short fresh run
      reset = 1'b1; tick();
      chk("rd_phase", 32'(bus.phase), 32'd0);
      chk("rd_busy", 32'(bus.busy), 32'd0);
      chk("rd_run", bus.run_cycles, 32'd0);
      chk("rd_start_div", 32'(bus.start_divider), 32'd0);
      reset = 1'b0;
      bus.start_in = 1'b1; tick();
      chk("fr_start_hist", 32'(bus.start_histogram), 32'd1);
      bus.start_in = 1'b0; bus.histogram_computation_done = 1'b1; tick();
      bus.histogram_computation_done = 1'b0; bus.cdf_done = 1'b1; tick();
      bus.cdf_done = 1'b0; bus.divider_done = 1'b1; tick();
      chk("fr_done", 32'(bus.done), 32'd1);
      chk("fr_run", bus.run_cycles, 32'd3);
      bus.divider_done = 1'b0; tick();

      // Random traffic against the model
      repeat (4000) begin
         drive_random();
         tick();
      end
      reset = 1'b0;
      clear_inputs();
      tick();
      tick();
      cmp_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
